apb_slave_regfile: RTL and testbench



---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_slave_regfile_if.sv | 24 ++
 rtl/apb_addr_decode.sv | 25 ++
 rtl/apb_slave_regfile.sv | 148 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB widths, register-bank sizing and responder FSM state encoding.
package apb_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int SEL_W     = 3;
  localparam int IDX_W     = 4;
  localparam int REG_SLOTS = 1 << IDX_W;
  localparam int CNT_W     = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus between the bridge (master) and a register-file responder (slave).
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic [SEL_W-1:0]  Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational decode of a byte address into a register index and error flag.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                NUM_REGS  = 8
) (
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  output logic [IDX_W-1:0]  idx,
  output logic              err
);

  logic [ADDR_W-1:0] offset;
  logic              hit;

  // Addresses below the base wrap to a huge offset and therefore miss.
  always_comb begin
    offset = paddr - BASE_ADDR;
    hit    = (offset < ADDR_W'(4 * NUM_REGS)) && (paddr[1:0] == 2'b00);
    idx    = offset[5:2];
    err    = !hit || (pwrite && (idx == '0));
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder with a bank of 32-bit registers, optional wait states and error replies.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                SEL_INDEX   = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'h0A9B_0001
) (
  input  logic              Hclk,
  input  logic              Hreset,
  apb_slave_regfile_if.slave apb,
  output logic [DATA_W-1:0] Reg1_out
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic              sel, access, capture, commit, resp;
  logic [IDX_W-1:0]  dec_idx, resp_idx;
  logic              dec_err, resp_err;
  logic [DATA_W-1:0] reg_vals [REG_SLOTS];
  logic              unused_pselx;

  assign unused_pselx = ^apb.Pselx;
  assign sel     = apb.Pselx[SEL_INDEX];
  assign access  = sel && apb.Penable;
  assign capture = sel && !apb.Penable && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign commit  = (state_q == ST_RESP) && write_q && !err_q;

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .paddr  (apb.Paddr),
    .pwrite (apb.Pwrite),
    .idx    (dec_idx),
    .err    (dec_err)
  );

  for (genvar gi = 0; gi < REG_SLOTS; gi++) begin : g_reg
    if (gi == 0) begin : g_id
      assign reg_vals[gi] = ID_VALUE;
    end else if (gi < NUM_REGS) begin : g_rw
      logic [DATA_W-1:0] data_q, data_d;
      always_comb data_d = (commit && (idx_q == IDX_W'(gi))) ? wdata_q : data_q;
      always_ff @(posedge Hclk) begin
        if (Hreset) data_q <= '0;
        else        data_q <= data_d;
      end
      assign reg_vals[gi] = data_q;
    end else begin : g_none
      assign reg_vals[gi] = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    resp      = 1'b0;
    resp_idx  = idx_q;
    resp_err  = err_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (capture) begin
          write_d = apb.Pwrite;
          wdata_d = apb.Pwdata;
          idx_d   = dec_idx;
          err_d   = dec_err;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            resp     = 1'b1;
            resp_idx = dec_idx;
            resp_err = dec_err;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      default: begin
        if (!access) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          resp    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
    endcase
    if (resp) begin
      pready_d  = 1'b1;
      pslverr_d = resp_err;
      // Forward a same-edge commit so a read never returns the pre-write value.
      if (resp_err)                           prdata_d = '0;
      else if (commit && (resp_idx == idx_q)) prdata_d = wdata_q;
      else                                    prdata_d = reg_vals[resp_idx];
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.Prdata  = prdata_q;
  assign apb.Pready  = pready_q;
  assign apb.Pslverr = pslverr_q;
  assign Reg1_out    = reg_vals[1];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three responders (0, 3 and 2 wait states) driven by table vectors and corner sequences.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  int          tgt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 Hclk = ~Hclk;
  always @(posedge Hclk) cyc <= cyc + 1;

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus3 ();
  apb_slave_regfile_if bus2 ();
  logic [31:0] reg1_0, reg1_3, reg1_2;

  assign bus0.Pselx = (tgt == 0) ? pselx : 3'b000;
  assign bus3.Pselx = (tgt == 1) ? pselx : 3'b000;
  assign bus2.Pselx = (tgt == 2) ? pselx : 3'b000;
  assign bus0.Penable = penable; assign bus0.Pwrite = pwrite;
  assign bus0.Paddr = paddr;     assign bus0.Pwdata = pwdata;
  assign bus3.Penable = penable; assign bus3.Pwrite = pwrite;
  assign bus3.Paddr = paddr;     assign bus3.Pwdata = pwdata;
  assign bus2.Penable = penable; assign bus2.Pwrite = pwrite;
  assign bus2.Paddr = paddr;     assign bus2.Pwdata = pwdata;

  apb_slave_regfile #(.SEL_INDEX(0), .WAIT_STATES(0)) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .apb(bus0), .Reg1_out(reg1_0));
  apb_slave_regfile #(.SEL_INDEX(1), .WAIT_STATES(3)) dut3 (
    .Hclk(Hclk), .Hreset(Hreset), .apb(bus3), .Reg1_out(reg1_3));
  apb_slave_regfile #(.SEL_INDEX(2), .WAIT_STATES(2)) dut2 (
    .Hclk(Hclk), .Hreset(Hreset), .apb(bus2), .Reg1_out(reg1_2));

  logic [31:0] mon_rdata, mon_reg1;
  logic        mon_ready, mon_err;
  always_comb begin
    case (tgt)
      1: begin mon_rdata = bus3.Prdata; mon_ready = bus3.Pready; mon_err = bus3.Pslverr; mon_reg1 = reg1_3; end
      2: begin mon_rdata = bus2.Prdata; mon_ready = bus2.Pready; mon_err = bus2.Pslverr; mon_reg1 = reg1_2; end
      default: begin mon_rdata = bus0.Prdata; mon_ready = bus0.Pready; mon_err = bus0.Pslverr; mon_reg1 = reg1_0; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic xfer(input int t, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd_o, output logic err_o, output int waits_o);
    logic done;
    done = 1'b0; rd_o = 'x; err_o = 1'bx; waits_o = 0;
    tgt = t; pselx = 3'b001 << t; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge Hclk); #1;
    penable = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Hclk);
      if (mon_ready) begin
        rd_o = mon_rdata; err_o = mon_err; done = 1'b1;
      end else begin
        waits_o++;
      end
      @(posedge Hclk); #1;
    end
    pselx = 3'b000; penable = 1'b0;
    chk("xfer_completed", 32'(done), 32'd1);
    $display("txn dut%0d %s addr=%08h wdata=%08h rdata=%08h err=%0b waits=%0d",
             t, wr ? "WR" : "RD", addr, wd, rd_o, err_o, waits_o);
  endtask

  typedef struct {
    int          t;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
    logic [31:0] exp_reg1;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] rd;
  logic        err;
  int          waits;
  int          c0;

  initial begin
    vecs[0]  = '{0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 32'hDEAD_BEEF};
    vecs[1]  = '{0, 1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF};
    vecs[2]  = '{0, 1'b1, 32'h8000_0000, 32'h1111_1111, 32'h0,         1'b1, 0, 32'hDEAD_BEEF};
    vecs[3]  = '{0, 1'b0, 32'h8000_0000, 32'h0,         32'h0A9B_0001, 1'b0, 0, 32'hDEAD_BEEF};
    vecs[4]  = '{0, 1'b0, 32'h8000_0020, 32'h0,         32'h0,         1'b1, 0, 32'hDEAD_BEEF};
    vecs[5]  = '{0, 1'b0, 32'h8000_0006, 32'h0,         32'h0,         1'b1, 0, 32'hDEAD_BEEF};
    vecs[6]  = '{0, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b1, 0, 32'hDEAD_BEEF};
    vecs[7]  = '{0, 1'b1, 32'h8000_001C, 32'hCAFE_F00D, 32'h0,         1'b0, 0, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 1'b0, 32'h8000_001C, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 32'hDEAD_BEEF};
    vecs[9]  = '{1, 1'b0, 32'h8000_0000, 32'h0,         32'h0A9B_0001, 1'b0, 3, 32'h0};
    vecs[10] = '{1, 1'b1, 32'h8000_0008, 32'h0000_00A5, 32'h0,         1'b0, 3, 32'h0};
    vecs[11] = '{1, 1'b0, 32'h8000_0008, 32'h0,         32'h0000_00A5, 1'b0, 3, 32'h0};
    vecs[12] = '{1, 1'b1, 32'h8000_0021, 32'h5A5A_5A5A, 32'h0,         1'b1, 3, 32'h0};
    vecs[13] = '{1, 1'b0, 32'h8000_0020, 32'h0,         32'h0,         1'b1, 3, 32'h0};
    vecs[14] = '{2, 1'b0, 32'h8000_000C, 32'h0,         32'h0,         1'b0, 2, 32'h0};

    Hreset = 1'b1; tgt = 0; pselx = 3'b000; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge Hclk);
    #1 Hreset = 1'b0;
    @(negedge Hclk);
    chk("reset_pready0",  32'(bus0.Pready),  32'd0);
    chk("reset_pslverr0", 32'(bus0.Pslverr), 32'd0);
    chk("reset_prdata0",  bus0.Prdata,       32'h0);
    chk("reset_reg1_0",   reg1_0,            32'h0);
    chk("reset_pready3",  32'(bus3.Pready),  32'd0);
    chk("reset_pready2",  32'(bus2.Pready),  32'd0);
    @(posedge Hclk); #1;

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].t, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, waits);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
      chk($sformatf("vec%0d_reg1", i), mon_reg1, vecs[i].exp_reg1);
    end

    // Wrong select bit: the WAIT_STATES=0 responder must stay silent.
    tgt = 0; pselx = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0004; pwdata = 32'h5555_5555;
    @(posedge Hclk); #1; penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Hclk);
      chk($sformatf("wrongsel_pready%0d", i), 32'(mon_ready), 32'd0);
      @(posedge Hclk); #1;
    end
    pselx = 3'b000; penable = 1'b0;
    @(posedge Hclk); #1;
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, rd, err, waits);
    chk("wrongsel_reg1_kept", rd, 32'hDEAD_BEEF);

    // Abort: select dropped in the WAIT cycle of a two-wait write.
    tgt = 2; pselx = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0008; pwdata = 32'h1234_5678;
    @(posedge Hclk); #1; penable = 1'b1;
    @(negedge Hclk); chk("abort_pready_a1", 32'(mon_ready), 32'd0);
    @(posedge Hclk); #1; pselx = 3'b000;
    @(negedge Hclk); chk("abort_pready_a2", 32'(mon_ready), 32'd0);
    @(posedge Hclk); #1;
    @(negedge Hclk); chk("abort_pready_a3", 32'(mon_ready), 32'd0);
    chk("abort_pslverr", 32'(mon_err), 32'd0);
    @(posedge Hclk); #1; penable = 1'b0;
    xfer(2, 1'b0, 32'h8000_0008, 32'h0, rd, err, waits);
    chk("abort_reg2_unchanged", rd, 32'h0);
    chk("abort_read_waits", 32'(waits), 32'd2);

    // Back-to-back writes then an immediate read of the just-written register.
    c0 = cyc;
    xfer(0, 1'b1, 32'h8000_0008, 32'h2222_0002, rd, err, waits);
    chk("b2b_w2_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 32'h8000_000C, 32'h3333_0003, rd, err, waits);
    chk("b2b_w3_waits", 32'(waits), 32'd0);
    chk("b2b_two_xfer_cycles", 32'(cyc - c0), 32'd4);
    xfer(0, 1'b0, 32'h8000_000C, 32'h0, rd, err, waits);
    chk("b2b_rd3", rd, 32'h3333_0003);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, rd, err, waits);
    chk("b2b_rd2", rd, 32'h2222_0002);

    // Reset during the access cycle of a write to register 1.
    tgt = 0; pselx = 3'b001; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_0004; pwdata = 32'hFFFF_FFFF;
    @(posedge Hclk); #1; penable = 1'b1; Hreset = 1'b1;
    @(negedge Hclk); chk("rst_access_pready", 32'(mon_ready), 32'd1);
    @(posedge Hclk); #1; Hreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Hclk);
      chk($sformatf("rst_noresp_pready%0d", i), 32'(mon_ready), 32'd0);
      chk($sformatf("rst_reg1_%0d", i), mon_reg1, 32'h0);
      @(posedge Hclk); #1;
    end
    pselx = 3'b000; penable = 1'b0;
    @(posedge Hclk); #1;
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, rd, err, waits);
    chk("rst_reg1_read", rd, 32'h0);
    chk("rst_reg1_waits", 32'(waits), 32'd0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, waits);
    chk("rst_id_read", rd, 32'h0A9B_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
